turn_control: RTL and testbench
===============================

TURN_CONTROL -- requirements
Module: turn_control

Interface
REQ-001 Parameter CLK_HZ, default 60_000_000, clock cycles per one-second tick.
REQ-002 Parameter TURN_SECONDS, default 10, turn time limit in seconds; legal range 1..15.
REQ-003 clk60MHz  input  1  system clock; single clock domain.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 local_ready  input  1  local side has chosen a player (level).
REQ-006 remote_ready  input  1  remote side has chosen a player (level).
REQ-007 current_player  input  1  local side's player: 0 = PLAYER_1, 1 = PLAYER_2; sampled only on game start.
REQ-008 throw_done  input  1  one-cycle pulse: local throw finished.
REQ-009 remote_throw_done  input  1  one-cycle pulse: remote throw finished.
REQ-010 game_over  input  1  one-cycle pulse: hit or end condition detected.
REQ-011 game_started  output  1  high from game start until reset.
REQ-012 active_player  output  1  player whose turn it is: 0 = PLAYER_1, 1 = PLAYER_2.
REQ-013 my_turn  output  1  high while the active player is the local player.
REQ-014 seconds_left  output  4  remaining seconds of the current turn.
REQ-015 turn_count  output  8  number of completed turns.
REQ-016 timeout  output  1  one-cycle pulse when a turn expires.

Function
REQ-017 The block SHALL register all outputs; each output changes on the same edge as the state transition that causes it.
REQ-018 The state machine SHALL have four states: WAIT_READY, P1_TURN, P2_TURN and OVER.
REQ-019 WAIT_READY -> P1_TURN SHALL occur when local_ready and remote_ready are both sampled high.
- On that edge: latch current_player as local_player; game_started = 1.
- PLAYER_1 always starts.
REQ-020 On entering a turn state the block SHALL:
- load seconds_left = TURN_SECONDS;
- clear the tick prescaler;
- set active_player to the turn's player;
- set my_turn = (active_player == local_player).
REQ-021 The prescaler SHALL count 0..CLK_HZ-1 in turn states and emit one tick on wrap; seconds_left SHALL decrement by 1 on each tick.
REQ-022 A turn SHALL end on the first of the following:
- throw_done while my_turn = 1;
- remote_throw_done while my_turn = 0;
- a tick with seconds_left == 1.
REQ-023 A throw pulse from the non-active side SHALL be ignored.
REQ-024 At turn end the block SHALL:
- go to the other turn state one cycle after the sampled event;
- increment turn_count, saturating at 255.
REQ-025 On a timeout-caused turn end, timeout SHALL pulse high for exactly one cycle on the transition edge; otherwise timeout = 0.
REQ-026 In P1_TURN or P2_TURN, game_over SHALL move the block to OVER.
- Priority: game_over wins over a simultaneous throw or timeout.
- turn_count is not incremented.
REQ-027 In OVER the block SHALL:
- hold active_player, turn_count and seconds_left;
- force my_turn = 0;
- stay until rst.
REQ-028 game_over, throw_done and remote_throw_done SHALL be ignored in WAIT_READY.
REQ-029 Deassertion of local_ready or remote_ready after game start SHALL be ignored.

Reset
REQ-030 rst SHALL force the following, from any state including mid-turn:
- state = WAIT_READY;
- game_started = 0, active_player = 0, my_turn = 0;
- seconds_left = 0, turn_count = 0, timeout = 0;
- prescaler = 0, local_player = 0.
REQ-031 rst SHALL take priority over every other input on the same edge.

Verification
REQ-032 The bench SHALL run with CLK_HZ = 10 and TURN_SECONDS = 3, and SHALL cover these scenarios:
- Start: after reset, current_player = 1, both readies high -> next edge game_started = 1, active_player = 0, my_turn = 0, seconds_left = 3.
- Turn passing: in P1_TURN with local = PLAYER_1, pulse throw_done -> one cycle later active_player = 1, my_turn = 0, turn_count = 1, timeout = 0; a following throw_done is ignored; remote_throw_done -> back to PLAYER_1, turn_count = 2.
- Timeout: no throws for 30 cycles -> seconds_left steps 3, 2, 1; on the 30th cycle timeout = 1 for one cycle, active_player toggles, seconds_left = 3.
- Simultaneous events: game_over and the valid throw_done in the same cycle -> OVER, turn_count unchanged, my_turn = 0; later pulses have no effect.
- Reset mid-turn: rst at seconds_left = 2, turn_count = 5 -> all outputs return to their reset values and the block restarts only when both readies are high.
- Saturation: 260 turn ends -> turn_count stays at 255.

Source files
------------

// File: rtl/turn_control_if.sv
`default_nettype none
// ============================================================================
// Module      : turn_control_if
// Description : Ready/throw/game-over inputs and turn status outputs of the
//               turn controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface turn_control_if;
  logic       local_ready;
  logic       remote_ready;
  logic       current_player;
  logic       throw_done;
  logic       remote_throw_done;
  logic       game_over;
  logic       game_started;
  logic       active_player;
  logic       my_turn;
  logic [3:0] seconds_left;
  logic [7:0] turn_count;
  logic       timeout;

  modport master (
    output local_ready, remote_ready, current_player,
           throw_done, remote_throw_done, game_over,
    input  game_started, active_player, my_turn,
           seconds_left, turn_count, timeout
  );

  modport slave (
    input  local_ready, remote_ready, current_player,
           throw_done, remote_throw_done, game_over,
    output game_started, active_player, my_turn,
           seconds_left, turn_count, timeout
  );
endinterface
`default_nettype wire

// File: rtl/turn_control.sv
`default_nettype none
// ============================================================================
// Module      : turn_control
// Description : Two-player turn sequencer with a per-turn seconds countdown,
//               turn counter and timeout pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module turn_control #(
  parameter int CLK_HZ       = 60_000_000,
  parameter int TURN_SECONDS = 10
) (
  input  logic           clk60MHz,
  input  logic           rst,
  turn_control_if.slave  bus
);

  localparam int c_PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(CLK_HZ - 1);
  localparam logic [c_PRE_W-1:0] c_PRE_ONE = c_PRE_W'(1);
  localparam logic [3:0]         c_TURN    = 4'(TURN_SECONDS);

  typedef enum logic [1:0] {
    WAIT_READY = 2'd0,
    P1_TURN    = 2'd1,
    P2_TURN    = 2'd2,
    OVER       = 2'd3
  } state_t;

  state_t             r_state;
  logic [c_PRE_W-1:0] r_prescaler;
  logic               r_local_player;
  logic               r_game_started;
  logic               r_active_player;
  logic               r_my_turn;
  logic [3:0]         r_seconds_left;
  logic [7:0]         r_turn_count;
  logic               r_timeout;

  logic       w_tick;
  logic       w_throw;
  logic       w_expire;
  logic       w_next_player;
  logic [7:0] w_count_inc;

  assign w_tick        = (r_prescaler == c_PRE_MAX);
  // Only the side that owns the turn may end it with a throw.
  assign w_throw       = (bus.throw_done && r_my_turn) ||
                         (bus.remote_throw_done && !r_my_turn);
  assign w_expire      = w_tick && (r_seconds_left == 4'd1);
  assign w_next_player = ~r_active_player;
  assign w_count_inc   = (r_turn_count == 8'hFF) ? r_turn_count
                                                 : r_turn_count + 8'd1;

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      r_state         <= WAIT_READY;
      r_prescaler     <= '0;
      r_local_player  <= 1'b0;
      r_game_started  <= 1'b0;
      r_active_player <= 1'b0;
      r_my_turn       <= 1'b0;
      r_seconds_left  <= 4'd0;
      r_turn_count    <= 8'd0;
      r_timeout       <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        WAIT_READY: begin
          if (bus.local_ready && bus.remote_ready) begin
            r_state         <= P1_TURN;
            r_local_player  <= bus.current_player;
            r_game_started  <= 1'b1;
            r_active_player <= 1'b0;
            r_my_turn       <= (bus.current_player == 1'b0);
            r_seconds_left  <= c_TURN;
            r_prescaler     <= '0;
          end
        end
        P1_TURN, P2_TURN: begin
          if (bus.game_over) begin
            r_state     <= OVER;
            r_my_turn   <= 1'b0;
            r_prescaler <= '0;
          end else if (w_throw || w_expire) begin
            r_state         <= (r_state == P1_TURN) ? P2_TURN : P1_TURN;
            r_active_player <= w_next_player;
            r_my_turn       <= (w_next_player == r_local_player);
            r_seconds_left  <= c_TURN;
            r_prescaler     <= '0;
            r_turn_count    <= w_count_inc;
            // A throw landing on the expiry tick counts as a normal turn end.
            r_timeout       <= w_expire && !w_throw;
          end else begin
            if (w_tick) begin
              r_prescaler    <= '0;
              r_seconds_left <= r_seconds_left - 4'd1;
            end else begin
              r_prescaler <= r_prescaler + c_PRE_ONE;
            end
          end
        end
        OVER: begin
          r_my_turn <= 1'b0;
        end
        default: begin
          r_state <= WAIT_READY;
        end
      endcase
    end
  end

  assign bus.game_started  = r_game_started;
  assign bus.active_player = r_active_player;
  assign bus.my_turn       = r_my_turn;
  assign bus.seconds_left  = r_seconds_left;
  assign bus.turn_count    = r_turn_count;
  assign bus.timeout       = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_turn_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_turn_control
// Description : Directed self-checking bench for turn_control.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_turn_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  turn_control_if bus ();

  turn_control #(.CLK_HZ(10), .TURN_SECONDS(3)) dut (
    .clk60MHz (clk),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    bus.throw_done        = 1'b0;
    bus.remote_throw_done = 1'b0;
    bus.game_over         = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.local_ready    = 1'b0;
    bus.remote_ready   = 1'b0;
    bus.current_player = 1'b0;
    clear_pulses();
    step();
    rst = 1'b0;
  endtask

  task automatic start_game(input logic cp);
    bus.current_player = cp;
    bus.local_ready    = 1'b1;
    bus.remote_ready   = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks += 6;
    if (bus.game_started !== 1'b0) begin n_fail++; $display("FAIL rst_started: got %0d exp 0", bus.game_started); end
    if (bus.active_player !== 1'b0) begin n_fail++; $display("FAIL rst_active: got %0d exp 0", bus.active_player); end
    if (bus.my_turn !== 1'b0) begin n_fail++; $display("FAIL rst_my_turn: got %0d exp 0", bus.my_turn); end
    if (bus.seconds_left !== 4'd0) begin n_fail++; $display("FAIL rst_seconds: got %0d exp 0", bus.seconds_left); end
    if (bus.turn_count !== 8'd0) begin n_fail++; $display("FAIL rst_count: got %0d exp 0", bus.turn_count); end
    if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %0d exp 0", bus.timeout); end
  endtask

  task automatic test_start();
    do_reset();
    // Pulses before the game starts must do nothing.
    bus.game_over = 1'b1; bus.throw_done = 1'b1; bus.remote_throw_done = 1'b1;
    bus.local_ready = 1'b1;
    step();
    clear_pulses();
    n_checks += 2;
    if (bus.game_started !== 1'b0) begin n_fail++; $display("FAIL wait_started: got %0d exp 0", bus.game_started); end
    if (bus.turn_count !== 8'd0) begin n_fail++; $display("FAIL wait_count: got %0d exp 0", bus.turn_count); end

    start_game(1'b1);
    n_checks += 5;
    if (bus.game_started !== 1'b1) begin n_fail++; $display("FAIL start_started: got %0d exp 1", bus.game_started); end
    if (bus.active_player !== 1'b0) begin n_fail++; $display("FAIL start_active: got %0d exp 0", bus.active_player); end
    if (bus.my_turn !== 1'b0) begin n_fail++; $display("FAIL start_my_turn: got %0d exp 0", bus.my_turn); end
    if (bus.seconds_left !== 4'd3) begin n_fail++; $display("FAIL start_seconds: got %0d exp 3", bus.seconds_left); end
    if (bus.turn_count !== 8'd0) begin n_fail++; $display("FAIL start_count: got %0d exp 0", bus.turn_count); end

    // current_player change is ignored; local throw is not valid on remote's turn.
    bus.current_player = 1'b0;
    bus.throw_done = 1'b1;
    step();
    clear_pulses();
    n_checks += 2;
    if (bus.active_player !== 1'b0) begin n_fail++; $display("FAIL start_ignore_active: got %0d exp 0", bus.active_player); end
    if (bus.turn_count !== 8'd0) begin n_fail++; $display("FAIL start_ignore_count: got %0d exp 0", bus.turn_count); end

    bus.remote_throw_done = 1'b1;
    step();
    clear_pulses();
    n_checks += 3;
    if (bus.active_player !== 1'b1) begin n_fail++; $display("FAIL start_pass_active: got %0d exp 1", bus.active_player); end
    if (bus.my_turn !== 1'b1) begin n_fail++; $display("FAIL start_pass_my_turn: got %0d exp 1", bus.my_turn); end
    if (bus.turn_count !== 8'd1) begin n_fail++; $display("FAIL start_pass_count: got %0d exp 1", bus.turn_count); end
  endtask

  task automatic test_turn_passing();
    do_reset();
    start_game(1'b0);
    n_checks += 1;
    if (bus.my_turn !== 1'b1) begin n_fail++; $display("FAIL pass_init_my_turn: got %0d exp 1", bus.my_turn); end

    bus.local_ready = 1'b0;
    bus.remote_ready = 1'b0;
    bus.throw_done = 1'b1;
    step();
    clear_pulses();
    n_checks += 5;
    if (bus.active_player !== 1'b1) begin n_fail++; $display("FAIL pass1_active: got %0d exp 1", bus.active_player); end
    if (bus.my_turn !== 1'b0) begin n_fail++; $display("FAIL pass1_my_turn: got %0d exp 0", bus.my_turn); end
    if (bus.turn_count !== 8'd1) begin n_fail++; $display("FAIL pass1_count: got %0d exp 1", bus.turn_count); end
    if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL pass1_timeout: got %0d exp 0", bus.timeout); end
    if (bus.game_started !== 1'b1) begin n_fail++; $display("FAIL pass1_started: got %0d exp 1", bus.game_started); end

    bus.throw_done = 1'b1;
    step();
    clear_pulses();
    n_checks += 2;
    if (bus.active_player !== 1'b1) begin n_fail++; $display("FAIL pass_ignore_active: got %0d exp 1", bus.active_player); end
    if (bus.turn_count !== 8'd1) begin n_fail++; $display("FAIL pass_ignore_count: got %0d exp 1", bus.turn_count); end

    bus.remote_throw_done = 1'b1;
    step();
    clear_pulses();
    n_checks += 4;
    if (bus.active_player !== 1'b0) begin n_fail++; $display("FAIL pass2_active: got %0d exp 0", bus.active_player); end
    if (bus.my_turn !== 1'b1) begin n_fail++; $display("FAIL pass2_my_turn: got %0d exp 1", bus.my_turn); end
    if (bus.turn_count !== 8'd2) begin n_fail++; $display("FAIL pass2_count: got %0d exp 2", bus.turn_count); end
    if (bus.seconds_left !== 4'd3) begin n_fail++; $display("FAIL pass2_seconds: got %0d exp 3", bus.seconds_left); end
  endtask

  // Continues from the turn entered at the end of test_turn_passing.
  task automatic test_timeout();
    for (int i = 1; i <= 29; i++) begin
      step();
      n_checks++;
      if (bus.seconds_left !== 4'(3 - i / 10) || bus.timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL countdown cycle %0d: seconds %0d timeout %0d exp seconds %0d timeout 0",
                 i, bus.seconds_left, bus.timeout, 3 - i / 10);
      end
    end
    step();
    n_checks += 4;
    if (bus.timeout !== 1'b1) begin n_fail++; $display("FAIL to_pulse: got %0d exp 1", bus.timeout); end
    if (bus.active_player !== 1'b1) begin n_fail++; $display("FAIL to_active: got %0d exp 1", bus.active_player); end
    if (bus.seconds_left !== 4'd3) begin n_fail++; $display("FAIL to_seconds: got %0d exp 3", bus.seconds_left); end
    if (bus.turn_count !== 8'd3) begin n_fail++; $display("FAIL to_count: got %0d exp 3", bus.turn_count); end
    step();
    n_checks += 1;
    if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL to_one_cycle: got %0d exp 0", bus.timeout); end
  endtask

  // Remote (player 2) owns the turn here; its throw collides with game_over.
  task automatic test_game_over_priority();
    bus.game_over = 1'b1;
    bus.remote_throw_done = 1'b1;
    step();
    clear_pulses();
    n_checks += 5;
    if (bus.my_turn !== 1'b0) begin n_fail++; $display("FAIL over_my_turn: got %0d exp 0", bus.my_turn); end
    if (bus.turn_count !== 8'd3) begin n_fail++; $display("FAIL over_count: got %0d exp 3", bus.turn_count); end
    if (bus.active_player !== 1'b1) begin n_fail++; $display("FAIL over_active: got %0d exp 1", bus.active_player); end
    if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL over_timeout: got %0d exp 0", bus.timeout); end
    if (bus.seconds_left !== 4'd3) begin n_fail++; $display("FAIL over_seconds: got %0d exp 3", bus.seconds_left); end

    bus.throw_done = 1'b1;
    step();
    clear_pulses();
    bus.remote_throw_done = 1'b1;
    step();
    clear_pulses();
    for (int i = 0; i < 40; i++) step();
    n_checks += 6;
    if (bus.my_turn !== 1'b0) begin n_fail++; $display("FAIL over_hold_my_turn: got %0d exp 0", bus.my_turn); end
    if (bus.turn_count !== 8'd3) begin n_fail++; $display("FAIL over_hold_count: got %0d exp 3", bus.turn_count); end
    if (bus.active_player !== 1'b1) begin n_fail++; $display("FAIL over_hold_active: got %0d exp 1", bus.active_player); end
    if (bus.seconds_left !== 4'd3) begin n_fail++; $display("FAIL over_hold_seconds: got %0d exp 3", bus.seconds_left); end
    if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL over_hold_timeout: got %0d exp 0", bus.timeout); end
    if (bus.game_started !== 1'b1) begin n_fail++; $display("FAIL over_hold_started: got %0d exp 1", bus.game_started); end
  endtask

  task automatic test_reset_mid_turn();
    do_reset();
    start_game(1'b0);
    // Exactly one of the two throws is valid each cycle, so each cycle ends a turn.
    bus.throw_done = 1'b1;
    bus.remote_throw_done = 1'b1;
    for (int i = 0; i < 5; i++) step();
    clear_pulses();
    for (int i = 0; i < 10; i++) step();
    n_checks += 2;
    if (bus.seconds_left !== 4'd2) begin n_fail++; $display("FAIL mid_seconds: got %0d exp 2", bus.seconds_left); end
    if (bus.turn_count !== 8'd5) begin n_fail++; $display("FAIL mid_count: got %0d exp 5", bus.turn_count); end

    rst = 1'b1;
    bus.throw_done = 1'b1; bus.remote_throw_done = 1'b1; bus.game_over = 1'b1;
    step();
    rst = 1'b0;
    clear_pulses();
    bus.remote_ready = 1'b0;
    n_checks += 6;
    if (bus.game_started !== 1'b0) begin n_fail++; $display("FAIL mid_rst_started: got %0d exp 0", bus.game_started); end
    if (bus.active_player !== 1'b0) begin n_fail++; $display("FAIL mid_rst_active: got %0d exp 0", bus.active_player); end
    if (bus.my_turn !== 1'b0) begin n_fail++; $display("FAIL mid_rst_my_turn: got %0d exp 0", bus.my_turn); end
    if (bus.seconds_left !== 4'd0) begin n_fail++; $display("FAIL mid_rst_seconds: got %0d exp 0", bus.seconds_left); end
    if (bus.turn_count !== 8'd0) begin n_fail++; $display("FAIL mid_rst_count: got %0d exp 0", bus.turn_count); end
    if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL mid_rst_timeout: got %0d exp 0", bus.timeout); end

    for (int i = 0; i < 3; i++) step();
    n_checks += 1;
    if (bus.game_started !== 1'b0) begin n_fail++; $display("FAIL mid_one_ready: got %0d exp 0", bus.game_started); end
    bus.remote_ready = 1'b1;
    step();
    n_checks += 3;
    if (bus.game_started !== 1'b1) begin n_fail++; $display("FAIL mid_restart: got %0d exp 1", bus.game_started); end
    if (bus.seconds_left !== 4'd3) begin n_fail++; $display("FAIL mid_restart_seconds: got %0d exp 3", bus.seconds_left); end
    if (bus.my_turn !== 1'b1) begin n_fail++; $display("FAIL mid_restart_my_turn: got %0d exp 1", bus.my_turn); end
  endtask

  task automatic test_saturation();
    do_reset();
    start_game(1'b0);
    bus.throw_done = 1'b1;
    bus.remote_throw_done = 1'b1;
    for (int i = 0; i < 254; i++) step();
    n_checks += 1;
    if (bus.turn_count !== 8'd254) begin n_fail++; $display("FAIL sat_254: got %0d exp 254", bus.turn_count); end
    step();
    n_checks += 1;
    if (bus.turn_count !== 8'd255) begin n_fail++; $display("FAIL sat_255: got %0d exp 255", bus.turn_count); end
    for (int i = 0; i < 5; i++) step();
    clear_pulses();
    n_checks += 3;
    if (bus.turn_count !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d exp 255", bus.turn_count); end
    if (bus.active_player !== 1'b0) begin n_fail++; $display("FAIL sat_active: got %0d exp 0", bus.active_player); end
    if (bus.my_turn !== 1'b1) begin n_fail++; $display("FAIL sat_my_turn: got %0d exp 1", bus.my_turn); end
  endtask

  initial begin
    bus.local_ready       = 1'b0;
    bus.remote_ready      = 1'b0;
    bus.current_player    = 1'b0;
    bus.throw_done        = 1'b0;
    bus.remote_throw_done = 1'b0;
    bus.game_over         = 1'b0;
    test_reset();
    test_start();
    test_turn_passing();
    test_timeout();
    test_game_over_priority();
    test_reset_mid_turn();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
